// File: rtl/tank_pkg.sv
// Shared tank-game types: headings, missile states, missile box size.
// Imported by the tank and missile controllers.
package tank_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    FLIGHT   = 2'b01,
    COOLDOWN = 2'b10
  } msl_state_t;

  localparam int MISSILE_W = 8;
  localparam int MISSILE_H = 16;

  function automatic logic [10:0] ext11(input logic [9:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/rect_overlap.sv
// Half-open rectangle overlap test; any zero-sized edge means no rectangle.
// Sums are widened to 11 bits so positions near 1023 cannot wrap.
module rect_overlap
  import tank_pkg::*;
(
  input  logic [9:0] ax_i,
  input  logic [9:0] ay_i,
  input  logic [9:0] aw_i,
  input  logic [9:0] ah_i,
  input  logic [9:0] bx_i,
  input  logic [9:0] by_i,
  input  logic [9:0] bw_i,
  input  logic [9:0] bh_i,
  output logic       hit_o
);

  logic present;
  logic x_ovl;
  logic y_ovl;

  assign present = (|aw_i) & (|ah_i)
                 & (|bw_i) & (|bh_i);

  assign x_ovl =
    (ext11(ax_i) < ext11(bx_i) + ext11(bw_i)) &&
    (ext11(bx_i) < ext11(ax_i) + ext11(aw_i));

  assign y_ovl =
    (ext11(ay_i) < ext11(by_i) + ext11(bh_i)) &&
    (ext11(by_i) < ext11(ay_i) + ext11(ah_i));

  assign hit_o = present & x_ovl & y_ovl;

endmodule

// File: rtl/missile_controller.sv
// One missile: launch on fire edge, step per frame tick, collide, cool down.
// Drives color_mapper's missile inputs and the score logic's hit pulses.
module missile_controller
  import tank_pkg::*;
#(
  parameter int STEP            = 4,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int TANK_SIZE       = 16,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic [1:0] TankType,
  input  logic [9:0] TargetX,
  input  logic [9:0] TargetY,
  input  logic [9:0] WallX1,
  input  logic [9:0] WallY1,
  input  logic [9:0] WallXSize1,
  input  logic [9:0] WallYSize1,
  input  logic [9:0] WallX2,
  input  logic [9:0] WallY2,
  input  logic [9:0] WallXSize2,
  input  logic [9:0] WallYSize2,
  input  logic [9:0] WallX3,
  input  logic [9:0] WallY3,
  input  logic [9:0] WallXSize3,
  input  logic [9:0] WallYSize3,
  output logic [9:0] MissileX,
  output logic [9:0] MissileY,
  output logic [1:0] MissileType,
  output logic       MissileDisplay,
  output logic       target_hit,
  output logic       wall_hit
);

  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [9:0] MW = 10'(MISSILE_W);
  localparam logic [9:0] MH = 10'(MISSILE_H);
  localparam logic [9:0] TS = 10'(TANK_SIZE);
  localparam logic [9:0] SP = 10'(STEP);
  localparam logic [9:0] CX = 10'((TANK_SIZE - MISSILE_W) / 2);

  msl_state_t  state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  dir_t        type_q, type_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        fire_q;
  logic        frame_q;

  logic        tick;
  logic        fire_rise;
  logic [9:0]  spawn_x, spawn_y;
  logic        spawn_ok;
  logic [9:0]  step_x, step_y;
  logic        step_ok;
  logic        tgt_hit;
  logic [2:0]  wall_hits;
  logic        any_wall;

  logic [9:0]  wx [3];
  logic [9:0]  wy [3];
  logic [9:0]  ww [3];
  logic [9:0]  wh [3];

  assign tick      = frame_clk & ~frame_q;
  assign fire_rise = fire & ~fire_q;

  assign wx = '{WallX1, WallX2, WallX3};
  assign wy = '{WallY1, WallY2, WallY3};
  assign ww = '{WallXSize1, WallXSize2, WallXSize3};
  assign wh = '{WallYSize1, WallYSize2, WallYSize3};

  rect_overlap u_tgt (
    .ax_i (x_q),
    .ay_i (y_q),
    .aw_i (MW),
    .ah_i (MH),
    .bx_i (TargetX),
    .by_i (TargetY),
    .bw_i (TS),
    .bh_i (TS),
    .hit_o(tgt_hit)
  );

  for (genvar g = 0; g < 3; g++) begin : g_wall
    rect_overlap u_wall (
      .ax_i (x_q),
      .ay_i (y_q),
      .aw_i (MW),
      .ah_i (MH),
      .bx_i (wx[g]),
      .by_i (wy[g]),
      .bw_i (ww[g]),
      .bh_i (wh[g]),
      .hit_o(wall_hits[g])
    );
  end

  assign any_wall = |wall_hits;

  // Spawn box sits just ahead of the tank, centred on its heading axis.
  always_comb begin
    spawn_x  = TankX;
    spawn_y  = TankY;
    spawn_ok = 1'b0;
    unique case (dir_t'(TankType))
      DIR_UP: begin
        spawn_x  = TankX + CX;
        spawn_y  = TankY - MH;
        spawn_ok = TankY >= MH;
      end
      DIR_RIGHT: begin
        spawn_x  = TankX + TS;
        spawn_ok = ext11(TankX) + ext11(TS)
                   + ext11(MW) <= 11'(SCREEN_W);
      end
      DIR_DOWN: begin
        spawn_x  = TankX + CX;
        spawn_y  = TankY + TS;
        spawn_ok = ext11(TankY) + ext11(TS)
                   + ext11(MH) <= 11'(SCREEN_H);
      end
      DIR_LEFT: begin
        spawn_x  = TankX - MW;
        spawn_ok = TankX >= MW;
      end
    endcase
  end

  always_comb begin
    step_x  = x_q;
    step_y  = y_q;
    step_ok = 1'b0;
    unique case (type_q)
      DIR_UP: begin
        step_y  = y_q - SP;
        step_ok = y_q >= SP;
      end
      DIR_RIGHT: begin
        step_x  = x_q + SP;
        step_ok = ext11(x_q) + ext11(MW)
                  + ext11(SP) <= 11'(SCREEN_W);
      end
      DIR_DOWN: begin
        step_y  = y_q + SP;
        step_ok = ext11(y_q) + ext11(MH)
                  + ext11(SP) <= 11'(SCREEN_H);
      end
      DIR_LEFT: begin
        step_x  = x_q - SP;
        step_ok = x_q >= SP;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      type_q  <= DIR_UP;
      cnt_q   <= '0;
      fire_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      type_q  <= type_d;
      cnt_q   <= cnt_d;
      fire_q  <= fire;
      frame_q <= frame_clk;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    type_d  = type_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (fire_rise && spawn_ok) begin
          state_d = FLIGHT;
          x_d     = spawn_x;
          y_d     = spawn_y;
          type_d  = dir_t'(TankType);
        end
      end
      FLIGHT: begin
        // Collision outranks a same-cycle tick.
        if (tgt_hit || any_wall) begin
          state_d = COOLDOWN;
          cnt_d   = CW'(COOLDOWN_FRAMES);
        end else if (tick) begin
          if (step_ok) begin
            x_d = step_x;
            y_d = step_y;
          end else begin
            state_d = COOLDOWN;
            cnt_d   = CW'(COOLDOWN_FRAMES);
          end
        end
      end
      COOLDOWN: begin
        if (tick) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q <= CW'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    MissileX       = x_q;
    MissileY       = y_q;
    MissileType    = type_q;
    MissileDisplay = 1'b0;
    target_hit     = 1'b0;
    wall_hit       = 1'b0;
    if (state_q == FLIGHT) begin
      MissileDisplay = 1'b1;
      target_hit     = tgt_hit;
      wall_hit       = ~tgt_hit & any_wall;
    end
  end

endmodule
